// File: rtl/cache_axi_bridge.sv
// Cache-line bridge between a simple cache bus and an AXI4 master port.
// Refills (reads) and evictions (writes) run on two independent FSMs, so an
// evict and a refill can be in flight at the same time. Every burst is
// two 64-bit beats (len=1, size=8 bytes, INCR) on a 16-byte aligned address.
//
// Handshake rule for every AXI channel: a transfer happens at a rising edge
// where valid and ready are both high; once valid is raised, it and its
// payload are held unchanged until that transfer happens.
module cache_axi_bridge (
  input  logic        clock,
  input  logic        reset,
  // cache write side
  input  logic        io_cache_bus_w_valid,
  input  logic [63:0] io_cache_bus_w_bits_waddr,
  input  logic [63:0] io_cache_bus_w_bits_wdata,
  input  logic        io_cache_bus_w_bits_wlast,
  output logic        io_cache_bus_w_ready,
  // cache write response
  input  logic        io_cache_bus_b_ready,
  output logic        io_cache_bus_b_valid,
  // cache read side
  input  logic        io_cache_bus_r_valid,
  input  logic [63:0] io_cache_bus_r_bits_raddr,
  output logic        io_cache_bus_r_ready,
  output logic [63:0] io_cache_bus_r_bits_rdata,
  output logic        io_cache_bus_r_bits_rlast,
  // AXI AW
  output logic        io_axi_aw_valid,
  input  logic        io_axi_aw_ready,
  output logic [63:0] io_axi_aw_addr,
  output logic [7:0]  io_axi_aw_len,
  output logic [2:0]  io_axi_aw_size,
  output logic [1:0]  io_axi_aw_burst,
  // AXI W
  output logic        io_axi_w_valid,
  input  logic        io_axi_w_ready,
  output logic [63:0] io_axi_w_data,
  output logic [7:0]  io_axi_w_strb,
  output logic        io_axi_w_last,
  // AXI B
  input  logic        io_axi_b_valid,
  output logic        io_axi_b_ready,
  input  logic [1:0]  io_axi_b_resp,
  // AXI AR
  output logic        io_axi_ar_valid,
  input  logic        io_axi_ar_ready,
  output logic [63:0] io_axi_ar_addr,
  output logic [7:0]  io_axi_ar_len,
  output logic [2:0]  io_axi_ar_size,
  output logic [1:0]  io_axi_ar_burst,
  // AXI R
  input  logic        io_axi_r_valid,
  output logic        io_axi_r_ready,
  input  logic [63:0] io_axi_r_data,
  input  logic        io_axi_r_last,
  input  logic [1:0]  io_axi_r_resp,
  // sticky error flag
  output logic        io_bus_err
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_WAIT} r_state_t;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_B} w_state_t;

  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;

  logic [63:0] r_addr_q;
  logic        r_beat_q;
  logic        r_strobe_q;
  logic [63:0] r_data_q;
  logic        r_last_q;
  logic [63:0] w_addr_q;
  logic        err_q;

  logic        r_fire;
  logic        r_err_evt;
  logic        b_err_evt;

  // The low address nibble is always replaced by zero on the AXI side.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{io_cache_bus_r_bits_raddr[3:0], io_cache_bus_w_bits_waddr[3:0]};

  // Burst shape never changes: two 8-byte INCR beats, all byte lanes written.
  assign io_axi_ar_len   = 8'd1;
  assign io_axi_ar_size  = 3'd3;
  assign io_axi_ar_burst = 2'b01;
  assign io_axi_aw_len   = 8'd1;
  assign io_axi_aw_size  = 3'd3;
  assign io_axi_aw_burst = 2'b01;
  assign io_axi_w_strb   = 8'hFF;

  assign io_axi_ar_addr  = r_addr_q;
  assign io_axi_aw_addr  = w_addr_q;

  // Cache read beats are replayed one cycle after the AXI beat lands.
  assign io_cache_bus_r_ready      = r_strobe_q;
  assign io_cache_bus_r_bits_rdata = r_data_q;
  assign io_cache_bus_r_bits_rlast = r_last_q;

  assign io_bus_err = err_q;

  assign r_fire    = (r_state == R_DATA) && io_axi_r_valid;
  // The burst length is owned by our beat counter; r_last only cross-checks it.
  assign r_err_evt = r_fire && ((io_axi_r_last != r_beat_q) || (io_axi_r_resp != 2'b00));
  assign b_err_evt = (w_state == W_RESP) && io_axi_b_valid && (io_axi_b_resp != 2'b00);

  // Read FSM: next state and AR/R handshake outputs.
  always_comb begin
    r_next          = r_state;
    io_axi_ar_valid = 1'b0;
    io_axi_r_ready  = 1'b0;
    case (r_state)
      R_IDLE: if (io_cache_bus_r_valid) r_next = R_AR;
      R_AR: begin
        io_axi_ar_valid = 1'b1;
        if (io_axi_ar_ready) r_next = R_DATA;
      end
      R_DATA: begin
        io_axi_r_ready = 1'b1;
        if (io_axi_r_valid && r_beat_q) r_next = R_WAIT;
      end
      // Last beat is handed to the cache here; idle afterwards with r_valid gone.
      R_WAIT: r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM state, captured address, beat counter and cache-side beat register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= R_IDLE;
      r_addr_q   <= 64'd0;
      r_beat_q   <= 1'b0;
      r_strobe_q <= 1'b0;
      r_data_q   <= 64'd0;
      r_last_q   <= 1'b0;
    end else begin
      r_state    <= r_next;
      r_strobe_q <= r_fire;
      r_last_q   <= r_fire & r_beat_q;
      if (r_state == R_IDLE && io_cache_bus_r_valid)
        r_addr_q <= {io_cache_bus_r_bits_raddr[63:4], 4'h0};
      if (r_state == R_AR && io_axi_ar_ready)
        r_beat_q <= 1'b0;
      else if (r_fire)
        r_beat_q <= ~r_beat_q;
      if (r_fire)
        r_data_q <= io_axi_r_data;
    end
  end

  // Write FSM: next state, AW request, W pass-through and B handling.
  always_comb begin
    w_next               = w_state;
    io_axi_aw_valid      = 1'b0;
    io_axi_w_valid       = 1'b0;
    io_axi_w_data        = 64'd0;
    io_axi_w_last        = 1'b0;
    io_cache_bus_w_ready = 1'b0;
    io_axi_b_ready       = 1'b0;
    io_cache_bus_b_valid = 1'b0;
    case (w_state)
      W_IDLE: if (io_cache_bus_w_valid) w_next = W_AW;
      W_AW: begin
        // Data is held off until the address has been accepted.
        io_axi_aw_valid = 1'b1;
        if (io_axi_aw_ready) w_next = W_DATA;
      end
      W_DATA: begin
        io_axi_w_valid       = io_cache_bus_w_valid;
        io_axi_w_data        = io_cache_bus_w_bits_wdata;
        io_axi_w_last        = io_cache_bus_w_bits_wlast;
        io_cache_bus_w_ready = io_axi_w_ready;
        if (io_cache_bus_w_valid && io_axi_w_ready && io_cache_bus_w_bits_wlast)
          w_next = W_RESP;
      end
      W_RESP: begin
        io_axi_b_ready = 1'b1;
        if (io_axi_b_valid) w_next = W_B;
      end
      W_B: begin
        io_cache_bus_b_valid = 1'b1;
        if (io_cache_bus_b_ready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM state and captured write address.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state  <= W_IDLE;
      w_addr_q <= 64'd0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && io_cache_bus_w_valid)
        w_addr_q <= {io_cache_bus_w_bits_waddr[63:4], 4'h0};
    end
  end

  // Sticky error flag: any bad response or misplaced r_last, cleared by reset only.
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (r_err_evt || b_err_evt) err_q <= 1'b1;
  end

endmodule
